cache_line_arbiter: RTL

- Sits directly downstream of the L1 icache and L1 dcache line ports.
- Multiplexes their 256-bit line read/write requests onto a single upstream memory port (L2 or physical memory).
- Serves one transaction at a time and returns the response only to the granted cache.
- Upstream sees exactly one outstanding request.

---
 rtl/cache_arb_pkg.sv | 28 ++
 rtl/cache_arb_grant.sv | 51 +++++
 rtl/cache_line_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg
// Shared types and constants for the cache line arbiter.
//   arb_state_t : arbiter FSM states (IDLE, SERVE_I, SERVE_D)
//   arb_op_t    : upstream operation captured at grant time
//   LINE_W      : cache line width in bits
//   OFFSET_W    : log2 of line bytes (address bits forced to zero upstream)
//   LAST_I/D    : encodings of the last-grant register
// Optional feature macro used by this slice: CACHE_ARB_ROUND_ROBIN_EN.
package cache_arb_pkg;

  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

endpackage

// File: rtl/cache_arb_grant.sv
// cache_arb_grant
// Combinational grant picker between the icache and dcache requesters.
// Ports:
//   i_req      : icache has a pending line request
//   d_req      : dcache has a pending line request (read or write)
//   last_grant : side granted most recently (LAST_I / LAST_D)
//   grant_i    : icache wins this cycle
//   grant_d    : dcache wins this cycle
// Macro CACHE_ARB_ROUND_ROBIN_EN: when defined, contention goes to the side
// not granted last; otherwise the dcache always wins contention.
module cache_arb_grant
  import cache_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant_i,
  output logic grant_d
);

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // Alternate on contention, grant a lone requester immediately
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_req && d_req) begin
      grant_d = (last_grant == LAST_I);
      grant_i = (last_grant == LAST_D);
    end else begin
      grant_i = i_req;
      grant_d = d_req;
    end
  end
`else
  // last_grant has no meaning under fixed priority
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant;

  // Fixed priority: the dcache wins any contention
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (d_req) begin
      grant_d = 1'b1;
    end else begin
      grant_i = i_req;
    end
  end
`endif

endmodule

// File: rtl/cache_line_arbiter.sv
// cache_line_arbiter
// Multiplexes icache and dcache 256-bit line requests onto one upstream
// memory port with a single outstanding transaction.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   i_read, i_addr             : icache line read request (held until i_resp)
//   i_resp, i_rdata256         : icache completion pulse and line data
//   d_read, d_write, d_addr,
//   d_wdata256                 : dcache fill/writeback request (held until d_resp)
//   d_resp, d_rdata256         : dcache completion pulse and line data
//   m_read, m_write, m_addr,
//   m_wdata256                 : upstream request (address offset bits zero)
//   m_resp, m_rdata256         : upstream completion pulse and read data
// Macro CACHE_ARB_ROUND_ROBIN_EN selects round-robin contention handling;
// undefined gives fixed dcache priority without a last-grant register.
module cache_line_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = cache_arb_pkg::LINE_W,
  parameter int OFFSET_W = cache_arb_pkg::OFFSET_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata256,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata256,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata256,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LINE_W-1:0] m_wdata256,
  input  logic              m_resp,
  input  logic [LINE_W-1:0] m_rdata256
);

  import cache_arb_pkg::*;

  arb_state_t        state_r;
  arb_state_t        next_state_s;
  logic              grant_i_s;
  logic              grant_d_s;
  logic              last_grant_s;
  arb_op_t           grant_op_s;
  logic [ADDR_W-1:0] grant_addr_s;
  logic [LINE_W-1:0] grant_wdata_s;
  logic              m_read_r;
  logic              m_write_r;
  logic [ADDR_W-1:0] m_addr_r;
  logic [LINE_W-1:0] m_wdata_r;

  cache_arb_grant u_grant (
    .i_req      (i_read),
    .d_req      (d_read | d_write),
    .last_grant (last_grant_s),
    .grant_i    (grant_i_s),
    .grant_d    (grant_d_s)
  );

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic last_grant_r;

  // Remember which side won the most recent grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= LAST_I;
    end else if ((state_r == IDLE) && grant_d_s) begin
      last_grant_r <= LAST_D;
    end else if ((state_r == IDLE) && grant_i_s) begin
      last_grant_r <= LAST_I;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign last_grant_s = last_grant_r;
`else
  assign last_grant_s = LAST_I;
`endif

  // Select the winner's operation, line address and write data
  always_comb begin
    grant_op_s    = OP_READ;
    grant_addr_s  = {ADDR_W{1'b0}};
    grant_wdata_s = {LINE_W{1'b0}};
    if (grant_d_s) begin
      // Writeback goes before fill when both are raised
      grant_op_s    = d_write ? OP_WRITE : OP_READ;
      grant_addr_s  = {d_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
      grant_wdata_s = d_wdata256;
    end else if (grant_i_s) begin
      grant_op_s    = OP_READ;
      grant_addr_s  = {i_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
      grant_wdata_s = {LINE_W{1'b0}};
    end else begin
      grant_op_s    = OP_READ;
    end
  end

  // Next-state logic: grant from IDLE, return to IDLE on m_resp
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          next_state_s = SERVE_D;
        end else if (grant_i_s) begin
          next_state_s = SERVE_I;
        end else begin
          next_state_s = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        if (m_resp) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Upstream request registers: load on grant, clear after m_resp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_read_r  <= 1'b0;
      m_write_r <= 1'b0;
      m_addr_r  <= {ADDR_W{1'b0}};
      m_wdata_r <= {LINE_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_d_s || grant_i_s) begin
            m_read_r  <= (grant_op_s == OP_READ);
            m_write_r <= (grant_op_s == OP_WRITE);
            m_addr_r  <= grant_addr_s;
            m_wdata_r <= grant_wdata_s;
          end
        end
        SERVE_I, SERVE_D: begin
          if (m_resp) begin
            m_read_r  <= 1'b0;
            m_write_r <= 1'b0;
          end
        end
        default: begin
          m_read_r  <= 1'b0;
          m_write_r <= 1'b0;
        end
      endcase
    end
  end

  assign m_read     = m_read_r;
  assign m_write    = m_write_r;
  assign m_addr     = m_addr_r;
  assign m_wdata256 = m_wdata_r;

  // Completion is routed only to the side currently being served
  assign i_resp = (state_r == SERVE_I) & m_resp;
  assign d_resp = (state_r == SERVE_D) & m_resp;

  assign i_rdata256 = m_rdata256;
  assign d_rdata256 = m_rdata256;

endmodule
